// File: rtl/hex_display_driver.sv
// hex_display_driver: registered multi-digit 7-segment driver with
// leading-zero suppression, global blank and per-digit blinking.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   reset    - synchronous, active-high reset
//   value    - packed nibbles, digit0 = value[3:0]
//   load     - capture value into held register this cycle
//   lz_en    - suppress leading zero digits (digit0 never suppressed)
//   blank    - force every digit dark
//   blink_en - per-digit blink mask, bit i -> digit i
//   seg      - digit i on seg[7i+6:7i], bit0=a .. bit6=g

module hex_display_driver #(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  blank,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CMAX =
    CW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] value_q;
  logic [CW-1:0]       cnt;
  logic                phase;
  logic [7*DIGITS-1:0] seg_d;
  logic [DIGITS:0]     hi_zero;
  logic [DIGITS-1:0]   dark;

  // Segment pattern, 1 = lit, bit0 = a.
  function automatic logic [6:0] dec7(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // hi_zero[i]: nibbles i..DIGITS-1 of value_q
  // are all zero, so digit i is a leading zero.
  always_comb begin
    hi_zero = '0;
    dark    = '0;
    seg_d   = '0;
    hi_zero[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero[i] = hi_zero[i+1] &
        (value_q[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      dark[i] = blank |
        (blink_en[i] & ~phase) |
        (lz_en & (i != 0) & hi_zero[i]);
      seg_d[7*i +: 7] = dark[i] ? 7'h00 :
        dec7(value_q[4*i +: 4]);
    end
    if (ACTIVE_LOW) seg_d = ~seg_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      cnt     <= '0;
      phase   <= 1'b1;
      seg     <= {7*DIGITS{ACTIVE_LOW}};
    end else begin
      if (load) value_q <= value;
      // Free-running divider; phase flips each
      // BLINK_DIV cycles so both halves match.
      if (cnt == CMAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: scoreboard bench for hex_display_driver,
// checks active-low, active-high and single-digit builds.

module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        lz_en;
  logic        blank;
  logic [3:0]  blink_en;
  logic [27:0] seg_lo;
  logic [27:0] seg_hi;
  logic [6:0]  seg_one;

  always #5 clk = ~clk;

  hex_display_driver #(
    .DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .value(value),
    .load(load), .lz_en(lz_en), .blank(blank),
    .blink_en(blink_en), .seg(seg_lo)
  );

  hex_display_driver #(
    .DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)
  ) u_pos (
    .clk(clk), .reset(reset), .value(value),
    .load(load), .lz_en(lz_en), .blank(blank),
    .blink_en(blink_en), .seg(seg_hi)
  );

  hex_display_driver #(
    .DIGITS(1), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) u_one (
    .clk(clk), .reset(reset), .value(value[3:0]),
    .load(load), .lz_en(lz_en), .blank(blank),
    .blink_en(blink_en[0]), .seg(seg_one)
  );

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_val;
  int          m_cnt;
  bit          m_ph;

  logic [27:0] q_lo [$];
  logic [27:0] q_hi [$];
  logic [6:0]  q_one [$];

  task automatic chk(
    input string       tag,
    input logic [27:0] got,
    input logic [27:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
        tag, got, exp);
    end
  endtask

  // Lit pattern (1 = on) from model state and
  // the inputs present at the edge.
  function automatic logic [27:0] lit();
    logic [27:0] r;
    logic [3:0]  nib;
    bit          lead;
    bit          off;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      nib  = m_val[4*d +: 4];
      lead = 1;
      for (int j = d; j < 4; j++)
        if (m_val[4*j +: 4] != 4'h0) lead = 0;
      off = blank ||
        (blink_en[d] && !m_ph) ||
        (lz_en && d != 0 && lead);
      r[7*d +: 7] = off ? 7'h00 : tbl[nib];
    end
    return r;
  endfunction

  task automatic step();
    logic [27:0] on;
    @(posedge clk);
    if (reset) begin
      q_lo.push_back({28{1'b1}});
      q_hi.push_back('0);
      q_one.push_back(7'h7F);
      m_val = '0;
      m_cnt = 0;
      m_ph  = 1;
    end else begin
      on = lit();
      q_lo.push_back(~on);
      q_hi.push_back(on);
      q_one.push_back(~on[6:0]);
      if (load) m_val = value;
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_ph  = !m_ph;
      end
    end
    #1;
    chk("sb_lo", seg_lo, q_lo.pop_front());
    chk("sb_hi", seg_hi, q_hi.pop_front());
    chk("sb_one", {21'b0, seg_one},
      {21'b0, q_one.pop_front()});
  endtask

  initial begin
    reset    = 1;
    value    = '0;
    load     = 0;
    lz_en    = 0;
    blank    = 0;
    blink_en = '0;
    m_val    = '0;
    m_cnt    = 0;
    m_ph     = 1;
    step();
    step();
    chk("rst_lo", seg_lo, {4{7'h7F}});
    chk("rst_hi", seg_hi, '0);

    // Decode and 2-clock latency.
    reset = 0;
    value = 16'h00A5;
    load  = 1;
    step();
    chk("lat1", seg_lo, {4{7'h40}});
    load = 0;
    step();
    chk("dec_a5", seg_lo,
      {7'h40, 7'h40, 7'h08, 7'h12});

    // All nibbles, streamed one per clock.
    for (int k = 0; k < 16; k++) begin
      value = {4{4'(k)}};
      load  = 1;
      step();
      if (k > 0)
        chk("nib", seg_lo, {4{~tbl[k-1]}});
    end
    load = 0;
    step();
    chk("nib_f", seg_lo, {4{~tbl[15]}});

    // Leading-zero suppression.
    lz_en = 1;
    value = 16'h00A5;
    load  = 1;
    step();
    load = 0;
    step();
    chk("lz_a5", seg_lo,
      {7'h7F, 7'h7F, 7'h08, 7'h12});
    value = 16'h0000;
    load  = 1;
    step();
    load = 0;
    step();
    chk("lz_0", seg_lo,
      {7'h7F, 7'h7F, 7'h7F, 7'h40});
    chk("one_lz", {21'b0, seg_one}, 28'h40);
    value = 16'h1000;
    load  = 1;
    step();
    load = 0;
    step();
    chk("lz_1000", seg_lo,
      {7'h79, 7'h40, 7'h40, 7'h40});
    lz_en = 0;

    // Blink digit0 from reset: 4 lit, 4 dark.
    blink_en = 4'b0001;
    reset    = 1;
    step();
    reset = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("blink_d0", {21'b0, seg_lo[6:0]},
        (((c - 1) / 4) % 2 == 0) ? 28'h40 : 28'h7F);
      chk("blink_hi", {7'b0, seg_lo[27:7]},
        {7'b0, {3{7'h40}}});
    end
    blink_en = '0;

    // Load streaming and hold.
    value = 16'h1111;
    load  = 1;
    step();
    value = 16'h2222;
    step();
    chk("st1", seg_lo, {4{7'h79}});
    value = 16'h3333;
    step();
    chk("st2", seg_lo, {4{7'h24}});
    value = 16'hFFFF;
    load  = 0;
    step();
    step();
    chk("hold", seg_lo, {4{7'h30}});

    // Reset priority in the middle of dark phase.
    blink_en = 4'b1111;
    for (int b = 0; b < 20; b++) begin
      if (!m_ph && m_cnt == 1) break;
      step();
    end
    chk("dark_mid", {27'b0, m_ph}, 28'h0);
    reset = 1;
    load  = 1;
    step();
    chk("rp_lo", seg_lo, {4{7'h7F}});
    reset = 0;
    load  = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rp_blink", seg_lo,
        (c < 4) ? {4{7'h40}} : {4{7'h7F}});
    end
    blink_en = '0;

    // Polarity and blank.
    value = 16'h0008;
    load  = 1;
    step();
    load = 0;
    step();
    chk("pos8", seg_hi,
      {7'h3F, 7'h3F, 7'h3F, 7'h7F});
    chk("one8", {21'b0, seg_one}, 28'h00);
    blank = 1;
    step();
    chk("blank_hi", seg_hi, '0);
    chk("blank_lo", seg_lo, {4{7'h7F}});
    blank = 0;

    // Random stream against the model.
    for (int r = 0; r < 80; r++) begin
      reset    = ($urandom_range(0, 29) == 0);
      value    = 16'($urandom);
      load     = ($urandom_range(0, 2) == 0);
      lz_en    = 1'($urandom);
      blank    = ($urandom_range(0, 7) == 0);
      blink_en = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
